// File: rtl/lcd_bus_responder_pkg.sv
// lcd_bus_responder_pkg: shared state encoding, register map and command helpers
package lcd_bus_responder_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} state_e;
  localparam logic [11:0] CMD_ADDR = 12'h880;
  localparam logic [11:0] STAT_ADDR = 12'h884;
  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME = 8'h02;
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == LCD_CLEAR || d == LCD_HOME);
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: small command queue; a push into a full queue is accepted when a pop happens in the same cycle
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop, do_push;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: memory-mapped HD44780-style write port with command queue and timed EN strobe
module lcd_bus_responder
  import lcd_bus_responder_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC = 2,
  parameter int WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_en_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic rs_q, rs_d, en_q, en_d, on_q, ovf_q;
  logic cmd_st, stat_st, pop, full, empty, busy, unused_bits;
  logic [8:0] head;
  logic [CW-1:0] count;
  assign cmd_st = st_en_i && addr_i == CMD_ADDR;
  assign stat_st = st_en_i && addr_i == STAT_ADDR;
  assign busy = state_q != ST_IDLE || !empty;
  assign ld_data_o = addr_i == STAT_ADDR ? {ovf_q, 24'd0, 3'(count), 1'b0, full, empty, busy} : 32'd0;
  assign lcd_data_o = data_q;
  assign lcd_rs_o = rs_q;
  assign lcd_rw_o = 1'b0;
  assign lcd_en_o = en_q;
  assign lcd_on_o = on_q;
  assign unused_bits = ^st_data_i[30:9];
  lcd_cmd_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push_i(cmd_st),
    .pop_i(pop),
    .data_i(st_data_i[8:0]),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  // sequencer: each phase loads the shared down-counter with its length minus one
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pop = 1'b0;
    data_d = data_q;
    rs_d = rs_q;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop = 1'b1;
        {rs_d, data_d} = head;
        cnt_d = 32'(SETUP_CYC - 1);
        state_d = ST_SETUP;
      end
      ST_SETUP: if (cnt_q == '0) begin
        cnt_d = 32'(PULSE_CYC - 1);
        state_d = ST_PULSE;
      end else cnt_d = cnt_q - 32'd1;
      ST_PULSE: if (cnt_q == '0) begin
        cnt_d = 32'(HOLD_CYC - 1);
        state_d = ST_HOLD;
      end else cnt_d = cnt_q - 32'd1;
      ST_HOLD: if (cnt_q == '0) begin
        cnt_d = is_long_cmd(rs_q, data_q) ? 32'(LONG_WAIT_CYC - 1) : 32'(WAIT_CYC - 1);
        state_d = ST_WAIT;
      end else cnt_d = cnt_q - 32'd1;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      else cnt_d = cnt_q - 32'd1;
      default: state_d = ST_IDLE;
    endcase
    en_d = state_d == ST_PULSE;
  end
  // sequencer state, latched command and registered EN so the strobe cannot glitch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      data_q <= '0;
      rs_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rs_q <= rs_d;
      en_q <= en_d;
    end
  end
  // backlight enable and sticky overflow; a push that coincides with a pop is not an overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      on_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      on_q <= stat_st ? st_data_i[0] : on_q;
      ovf_q <= (stat_st && st_data_i[31]) ? 1'b0 : (cmd_st && full && !pop) ? 1'b1 : ovf_q;
    end
  end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed vectors and timed scenarios for the LCD bus responder
module tb_lcd_bus_responder;
  import lcd_bus_responder_pkg::*;
  logic clk = 1'b0;
  logic rst_ni, st_en_i;
  logic [11:0] addr_i;
  logic [31:0] st_data_i, ld_data_o;
  logic [7:0] lcd_data_o;
  logic lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;
  int checks = 0;
  int errors = 0;
  int first_en, en_n, idle_k, post;
  bit done;
  typedef struct {
    logic        st;
    logic [11:0] st_addr;
    logic [31:0] st_data;
    logic [11:0] rd_addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  lcd_bus_responder #(
    .SETUP_CYC(1), .PULSE_CYC(4), .HOLD_CYC(1), .WAIT_CYC(8), .LONG_WAIT_CYC(32), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .st_en_i(st_en_i),
    .addr_i(addr_i),
    .st_data_i(st_data_i),
    .ld_data_o(ld_data_o),
    .lcd_data_o(lcd_data_o),
    .lcd_rs_o(lcd_rs_o),
    .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o),
    .lcd_on_o(lcd_on_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic burst(input logic [11:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      st_en_i = 1'b1;
      addr_i = a;
      st_data_i = d + 32'(i);
    end
    @(negedge clk);
    st_en_i = 1'b0;
    addr_i = STAT_ADDR;
    st_data_i = '0;
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    burst(a, d, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    addr_i = STAT_ADDR;
    #1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ld_data_o[0] === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic watch(input logic [7:0] first, input int n, input string nm);
    logic [7:0] prev;
    int got;
    prev = lcd_data_o;
    got = 0;
    for (int i = 0; i < 300 && got < n; i++) begin
      @(negedge clk);
      if (lcd_data_o !== prev) begin
        chk(nm, 32'(lcd_data_o), 32'(first) + 32'(got));
        prev = lcd_data_o;
        got++;
      end
    end
    chk({nm, "_count"}, got, n);
  endtask

  initial begin
    vecs[0] = '{1'b0, 12'h000, 32'h0, 12'h884, 32'h2};
    vecs[1] = '{1'b0, 12'h000, 32'h0, 12'h880, 32'h0};
    vecs[2] = '{1'b0, 12'h000, 32'h0, 12'h888, 32'h0};
    vecs[3] = '{1'b0, 12'h000, 32'h0, 12'h080, 32'h0};
    vecs[4] = '{1'b1, 12'h888, 32'h141, 12'h884, 32'h2};
    vecs[5] = '{1'b1, 12'h080, 32'h141, 12'h884, 32'h2};
    vecs[6] = '{1'b1, 12'h884, 32'h1, 12'h884, 32'h2};
    vecs[7] = '{1'b0, 12'h000, 32'h0, 12'h885, 32'h0};
    rst_ni = 1'b1;
    st_en_i = 1'b0;
    addr_i = STAT_ADDR;
    st_data_i = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rst_stat", ld_data_o, 32'h2);
    chk("rst_en", 32'(lcd_en_o), 32'd0);
    chk("rst_data", 32'(lcd_data_o), 32'h0);
    chk("rst_rs", 32'(lcd_rs_o), 32'd0);
    chk("rst_on", 32'(lcd_on_o), 32'd0);
    chk("rst_rw", 32'(lcd_rw_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].st) store(vecs[i].st_addr, vecs[i].st_data);
      addr_i = vecs[i].rd_addr;
      #1;
      chk($sformatf("vec%0d", i), ld_data_o, vecs[i].exp);
    end
    chk("dec_on", 32'(lcd_on_o), 32'd1);
    store(STAT_ADDR, 32'h0);
    chk("dec_off", 32'(lcd_on_o), 32'd0);
    wait_idle("dec_idle");
    store(CMD_ADDR, 32'h141);
    first_en = -1;
    en_n = 0;
    idle_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("basic_rs", 32'(lcd_rs_o), 32'd1);
        chk("basic_data", 32'(lcd_data_o), 32'h41);
      end
      if (lcd_en_o) begin
        en_n++;
        if (first_en < 0) first_en = k;
      end
      if (idle_k < 0 && !ld_data_o[0]) idle_k = k;
    end
    chk("basic_en_first", first_en, 2);
    chk("basic_en_len", en_n, 4);
    chk("basic_busy_low", idle_k, 15);
    chk("basic_rw", 32'(lcd_rw_o), 32'd0);
    store(CMD_ADDR, 32'h001);
    store(CMD_ADDR, 32'h038);
    chk("lw_rs", 32'(lcd_rs_o), 32'd0);
    chk("lw_data", 32'(lcd_data_o), 32'h01);
    en_n = 0;
    post = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (lcd_data_o !== 8'h01) done = 1'b1;
      else begin
        if (lcd_en_o) en_n++;
        else if (en_n > 0) post++;
        @(negedge clk);
      end
    end
    chk("lw_en_len", en_n, 4);
    chk("lw_hold_wait_idle", post, 34);
    chk("lw_next_seen", 32'(done), 32'd1);
    chk("lw_next_data", 32'(lcd_data_o), 32'h38);
    chk("lw_next_rs", 32'(lcd_rs_o), 32'd0);
    wait_idle("lw_idle");
    burst(CMD_ADDR, 32'h110, 6);
    chk("ovf_stat", ld_data_o, 32'h8000_0045);
    chk("ovf_first", 32'(lcd_data_o), 32'h10);
    store(STAT_ADDR, 32'h8000_0001);
    chk("ovf_clr_stat", ld_data_o, 32'h45);
    chk("ovf_on", 32'(lcd_on_o), 32'd1);
    watch(8'h11, 4, "ovf_order");
    wait_idle("ovf_idle");
    chk("ovf_end_stat", ld_data_o, 32'h2);
    chk("ovf_end_data", 32'(lcd_data_o), 32'h14);
    burst(CMD_ADDR, 32'h120, 5);
    repeat (10) @(negedge clk);
    store(CMD_ADDR, 32'h125);
    chk("pp_stat", ld_data_o, 32'h45);
    chk("pp_popped", 32'(lcd_data_o), 32'h21);
    watch(8'h22, 4, "pp_order");
    wait_idle("pp_idle");
    chk("pp_end_stat", ld_data_o, 32'h2);
    chk("pp_end_data", 32'(lcd_data_o), 32'h25);
    store(CMD_ADDR, 32'h141);
    store(CMD_ADDR, 32'h155);
    chk("rm_en_pre", 32'(lcd_en_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rm_en", 32'(lcd_en_o), 32'd0);
    chk("rm_stat", ld_data_o, 32'h2);
    chk("rm_data", 32'(lcd_data_o), 32'h0);
    chk("rm_on", 32'(lcd_on_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    en_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (lcd_en_o) en_n++;
    end
    chk("rm_quiet", en_n, 0);
    chk("rm_stat_after", ld_data_o, 32'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
